// File: rtl/acc_pkg.sv
// Shared types and default sizes for the accelerator memory path.
// Used by the arbiter and the accelerator control units.
package acc_pkg;

  localparam int ACC_NUM_ACC         = 4;
  localparam int ACC_ADDR_SIZE       = 16;
  localparam int ACC_READ_DATA_SIZE  = 512;
  localparam int ACC_WRITE_DATA_SIZE = 32;
  localparam int ACC_MEM_READ_LAT    = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESPOND
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/acc_rr_picker.sv
// Round-robin picker: first requester at or above ptr, with wrap.
// Pure combinational; grant is one-hot, idx is its binary index.
module acc_rr_picker #(
  parameter int NUM_ACC = 4,
  parameter int IDXW    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic [NUM_ACC-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_ACC-1:0] grant,
  output logic               valid,
  output logic [IDXW-1:0]    idx
);

  // scan upward from ptr, wrapping once around
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    grant = '0;
    j     = 0;
    for (int k = 0; k < NUM_ACC; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_ACC) j = j - NUM_ACC;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = IDXW'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Serializes accelerator read/write requests onto one memory port.
// Moore FSM: IDLE -> ISSUE -> (WAIT) -> RESPOND -> IDLE.
module acc_mem_arbiter
  import acc_pkg::*;
#(
  parameter int NUM_ACC          = ACC_NUM_ACC,
  parameter int ADDR_SIZE        = ACC_ADDR_SIZE,
  parameter int READ_DATA_SIZE   = ACC_READ_DATA_SIZE,
  parameter int WRITE_DATA_SIZE  = ACC_WRITE_DATA_SIZE,
  parameter int MEM_READ_LATENCY = ACC_MEM_READ_LAT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_ACC-1:0]                 acc_read_en,
  input  logic [NUM_ACC*ADDR_SIZE-1:0]       acc_read_addr,
  input  logic [NUM_ACC-1:0]                 acc_write_en,
  input  logic [NUM_ACC*ADDR_SIZE-1:0]       acc_write_addr,
  input  logic [NUM_ACC*WRITE_DATA_SIZE-1:0] acc_write_data,
  output logic [READ_DATA_SIZE-1:0]          acc_read_data,
  output logic [NUM_ACC-1:0]                 acc_read_data_valid,
  output logic [NUM_ACC-1:0]                 acc_write_done,
  output logic                               mem_read_en,
  output logic [ADDR_SIZE-1:0]               mem_read_addr,
  input  logic [READ_DATA_SIZE-1:0]          mem_read_data,
  output logic                               mem_write_en,
  output logic [ADDR_SIZE-1:0]               mem_write_addr,
  output logic [WRITE_DATA_SIZE-1:0]         mem_write_data
);

  localparam int IDXW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int CNTW = $clog2(MEM_READ_LATENCY + 1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MEM_READ_LATENCY - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_ACC - 1);

  arb_state_t                 state_q, state_d;
  op_t                        op_q, op_d;
  logic [IDXW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]            gnt_q, gnt_d;
  logic [ADDR_SIZE-1:0]       addr_q, addr_d;
  logic [WRITE_DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [READ_DATA_SIZE-1:0]  rdata_q, rdata_d;
  logic [CNTW-1:0]            cnt_q, cnt_d;

  logic [NUM_ACC-1:0] req;
  logic [NUM_ACC-1:0] pick_oh;
  logic               pick_vld;
  logic [IDXW-1:0]    pick_idx;
  logic               pick_wr;
  logic [NUM_ACC-1:0] gnt_oh;

  assign req     = acc_read_en | acc_write_en;
  assign pick_wr = |(pick_oh & acc_write_en);

  acc_rr_picker #(
    .NUM_ACC (NUM_ACC),
    .IDXW    (IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (pick_oh),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // next-state, latch capture and latency countdown
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d    = pick_idx;
          rr_ptr_d = (pick_idx == IDX_LAST) ? '0
                   : pick_idx + 1'b1;
          state_d  = S_ISSUE;
          if (pick_wr) begin
            op_d    = OP_WRITE;
            addr_d  = acc_write_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE];
            wdata_d = acc_write_data[pick_idx*WRITE_DATA_SIZE +:
                                     WRITE_DATA_SIZE];
          end else begin
            op_d   = OP_READ;
            addr_d = acc_read_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE];
          end
        end
      end
      S_ISSUE: begin
        if (op_q == OP_WRITE) begin
          state_d = S_RESPOND;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_read_data;
          state_d = S_RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // state and latch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_READ;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt_oh = NUM_ACC'(1) << gnt_q;

  assign mem_read_en    = (state_q == S_ISSUE) && (op_q == OP_READ);
  assign mem_write_en   = (state_q == S_ISSUE) && (op_q == OP_WRITE);
  assign mem_read_addr  = addr_q;
  assign mem_write_addr = addr_q;
  assign mem_write_data = wdata_q;
  assign acc_read_data  = rdata_q;

  assign acc_read_data_valid =
    (state_q == S_RESPOND && op_q == OP_READ) ? gnt_oh : '0;
  assign acc_write_done =
    (state_q == S_RESPOND && op_q == OP_WRITE) ? gnt_oh : '0;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Directed bench: one arbiter at latency 1 (a), one at latency 3 (b).
// Memory model returns a line derived from the read address.
module tb_acc_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int RW = 512;
  localparam int WW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    rd_en, wr_en;
  logic [N*AW-1:0] rd_addr, wr_addr;
  logic [N*WW-1:0] wr_data;

  logic [RW-1:0] rdata_a, mrd_a, rdata_b, mrd_b;
  logic [N-1:0]  vld_a, done_a, vld_b, done_b;
  logic          ren_a, wen_a, ren_b, wen_b;
  logic [AW-1:0] raddr_a, waddr_a, raddr_b, waddr_b;
  logic [WW-1:0] wdat_a, wdat_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  function automatic logic [RW-1:0] line(input logic [AW-1:0] a);
    return {480'h0, 16'hD00D, a};
  endfunction

  assign mrd_a = line(raddr_a);
  assign mrd_b = line(raddr_b);

  acc_mem_arbiter #(.MEM_READ_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .acc_read_en(rd_en), .acc_read_addr(rd_addr),
    .acc_write_en(wr_en), .acc_write_addr(wr_addr),
    .acc_write_data(wr_data),
    .acc_read_data(rdata_a), .acc_read_data_valid(vld_a),
    .acc_write_done(done_a),
    .mem_read_en(ren_a), .mem_read_addr(raddr_a),
    .mem_read_data(mrd_a),
    .mem_write_en(wen_a), .mem_write_addr(waddr_a),
    .mem_write_data(wdat_a)
  );

  acc_mem_arbiter #(.MEM_READ_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .acc_read_en(rd_en), .acc_read_addr(rd_addr),
    .acc_write_en(wr_en), .acc_write_addr(wr_addr),
    .acc_write_data(wr_data),
    .acc_read_data(rdata_b), .acc_read_data_valid(vld_b),
    .acc_write_done(done_b),
    .mem_read_en(ren_b), .mem_read_addr(raddr_b),
    .mem_read_data(mrd_b),
    .mem_write_en(wen_b), .mem_write_addr(waddr_b),
    .mem_write_data(wdat_b)
  );

  task automatic chk(input string tag,
                     input logic [RW-1:0] got,
                     input logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rd_en = '0;
    wr_en = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [N-1:0] oh(input int u);
    logic [N-1:0] v;
    v = '0;
    v[u] = 1'b1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int last;
    int n;
    int ord[2];
    logic [N-1:0] seen;
    rd_en = '0;
    wr_en = '0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;

    // reset values
    #2;
    chk("rst_ren", ren_a, 0);
    chk("rst_wen", wen_a, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_raddr", raddr_a, 0);
    chk("rst_waddr", waddr_a, 0);
    chk("rst_wdat", wdat_a, 0);
    chk("rst_ptr", dut_a.rr_ptr_q, 0);
    do_reset();

    // single write from unit 2
    wr_addr[2*AW +: AW] = 16'h5000;
    wr_data[2*WW +: WW] = 32'h5;
    wr_en[2] = 1'b1;
    tick();
    chk("w_wen", wen_a, 1);
    chk("w_ren", ren_a, 0);
    chk("w_addr", waddr_a, 16'h5000);
    chk("w_data", wdat_a, 32'h5);
    chk("w_done_early", done_a, 0);
    tick();
    chk("w_done", done_a, 4'b0100);
    wr_en[2] = 1'b0;
    tick();
    chk("w_done_1cyc", done_a, 0);

    // single read from unit 0
    do_reset();
    rd_addr[0 +: AW] = 16'h1000;
    rd_en[0] = 1'b1;
    tick();
    chk("r_ren", ren_a, 1);
    chk("r_addr", raddr_a, 16'h1000);
    tick();
    chk("r_vld_early", vld_a, 0);
    tick();
    chk("r_vld", vld_a, 4'b0001);
    chk("r_data", rdata_a, line(16'h1000));
    rd_en[0] = 1'b0;
    tick();
    chk("r_vld_1cyc", vld_a, 0);
    tick();
    tick();

    // four-way read contention
    do_reset();
    for (int u = 0; u < N; u++) begin
      rd_addr[u*AW +: AW] = AW'(16'h0100 * (u + 1));
    end
    rd_en = '1;
    last = -1;
    for (int u = 0; u < N; u++) begin
      n = 0;
      while (vld_a == '0 && n < 20) begin
        tick();
        n++;
      end
      chk("c_vld", vld_a, oh(u));
      chk("c_data", rdata_a, line(AW'(16'h0100 * (u + 1))));
      if (last >= 0) chk("c_gap", cyc - last, 4);
      last = cyc;
      rd_en[u] = 1'b0;
      tick();
    end

    // wrap: units 3 and 0 requesting, pointer back at 0
    rd_addr[3*AW +: AW] = 16'h0333;
    rd_addr[0 +: AW]    = 16'h0444;
    rd_en[3] = 1'b1;
    rd_en[0] = 1'b1;
    ord[0] = 0;
    ord[1] = 3;
    for (int i = 0; i < 2; i++) begin
      n = 0;
      while (vld_a == '0 && n < 20) begin
        tick();
        n++;
      end
      chk("wrap_vld", vld_a, oh(ord[i]));
      rd_en[ord[i]] = 1'b0;
      tick();
    end

    // both enables from unit 1: write first
    do_reset();
    rd_addr[1*AW +: AW] = 16'h0AAA;
    wr_addr[1*AW +: AW] = 16'h0BBB;
    wr_data[1*WW +: WW] = 32'h1234;
    rd_en[1] = 1'b1;
    wr_en[1] = 1'b1;
    tick();
    chk("b_wen", wen_a, 1);
    chk("b_ren", ren_a, 0);
    chk("b_waddr", waddr_a, 16'h0BBB);
    tick();
    chk("b_done", done_a, 4'b0010);
    chk("b_vld0", vld_a, 0);
    wr_en[1] = 1'b0;
    tick();
    chk("b_idle", {ren_a, wen_a}, 0);
    tick();
    chk("b_ren2", ren_a, 1);
    chk("b_wen2", wen_a, 0);
    chk("b_raddr", raddr_a, 16'h0AAA);
    tick();
    tick();
    chk("b_vld", vld_a, 4'b0010);
    chk("b_data", rdata_a, line(16'h0AAA));
    rd_en[1] = 1'b0;
    tick();

    // latency 3 read
    do_reset();
    rd_addr[2*AW +: AW] = 16'h2222;
    rd_en[2] = 1'b1;
    tick();
    chk("l3_ren", ren_b, 1);
    chk("l3_raddr", raddr_b, 16'h2222);
    tick();
    chk("l3_ren_1cyc", ren_b, 0);
    tick();
    tick();
    chk("l3_vld_early", vld_b, 0);
    tick();
    chk("l3_vld", vld_b, 4'b0100);
    chk("l3_data", rdata_b, line(16'h2222));
    rd_en[2] = 1'b0;
    tick();
    tick();
    tick();

    // reset while in WAIT
    rd_addr[1*AW +: AW] = 16'h1111;
    rd_en[1] = 1'b1;
    tick();
    tick();
    chk("rw_hold", rdata_b, line(16'h2222));
    chk("rw_raddr", raddr_b, 16'h1111);
    rst_n = 1'b0;
    rd_en = '0;
    #1;
    chk("rw_ren", ren_b, 0);
    chk("rw_raddr0", raddr_b, 0);
    chk("rw_rdata0", rdata_b, 0);
    chk("rw_vld0", vld_b, 0);
    chk("rw_ptr", dut_b.rr_ptr_q, 0);
    tick();
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | vld_b;
    end
    chk("rw_no_pulse", seen, 0);

    // requester drops write_en after grant
    do_reset();
    wr_addr[3*AW +: AW] = 16'h3333;
    wr_data[3*WW +: WW] = 32'hCAFE;
    wr_en[3] = 1'b1;
    tick();
    wr_en[3] = 1'b0;
    chk("d_wen", wen_a, 1);
    chk("d_waddr", waddr_a, 16'h3333);
    chk("d_wdat", wdat_a, 32'hCAFE);
    tick();
    chk("d_done", done_a, 4'b1000);
    tick();
    chk("d_done_1cyc", done_a, 0);
    tick();
    chk("d_idle", {ren_a, wen_a, done_a, vld_a}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
